// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Shared types and constants for the FIFO read-side blocks.
//  Revision : 1.0  - initial release
// ============================================================================
package fifo_pkg;

    // Read controller states, explicitly encoded in two bits
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    // Output buffer depth and the width needed to count 0..depth
    localparam int unsigned c_BUF_DEPTH = 2;
    localparam int unsigned c_CNT_W     = $clog2(c_BUF_DEPTH + 1);

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_skid_buf
//  Purpose  : Two-entry registered FIFO-ordered buffer. The head entry drives
//             dout directly from a register, so nothing on din reaches dout
//             combinationally.
//  Revision : 1.0  - initial release
// ============================================================================
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               push,
    input  logic [WIDTH-1:0]   din,
    input  logic               pop,
    output logic [WIDTH-1:0]   dout,
    output logic [c_CNT_W-1:0] count,
    input  logic               flush
);

    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(c_BUF_DEPTH);
    localparam logic [c_CNT_W-1:0] c_EMPTY = '0;
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [WIDTH-1:0]   r_head;
    logic [WIDTH-1:0]   r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic               w_pop_ok;
    logic               w_push_ok;

    // A pop is only meaningful with data present; a push into a full buffer
    // is accepted only if a pop frees a slot in the same cycle.
    assign w_pop_ok  = pop && (r_count != c_EMPTY);
    assign w_push_ok = push && ((r_count != c_FULL) || w_pop_ok);

    assign dout  = r_head;
    assign count = r_count;

    // Entry storage and occupancy; flush empties the buffer but leaves data
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10: begin
                    if (r_count == c_EMPTY) r_head <= din;
                    else                    r_tail <= din;
                    r_count <= r_count + c_ONE;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - c_ONE;
                end
                2'b11: begin
                    if (r_count == c_ONE) begin
                        r_head <= din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= din;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule : fifo_skid_buf
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_burst_reader
//  Purpose  : Pops a programmed burst of words from a show-ahead FIFO and
//             presents them on a registered valid/ready stream, tagging the
//             final word with out_last.
//  Revision : 1.0  - initial release
// ============================================================================
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    input  logic                  abort,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(c_BUF_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [LEN_W-1:0]   c_LEN_ONE = LEN_W'(1);

    rd_state_e             r_state;
    rd_state_e             w_state_nxt;
    logic [LEN_W-1:0]      r_remaining;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  w_rd_en;
    logic                  w_buf_pop;
    logic [c_CNT_W-1:0]    w_count;
    logic [DATA_WIDTH:0]   w_buf_din;
    logic [DATA_WIDTH:0]   w_buf_dout;

    // A word leaves the buffer whenever the consumer handshakes
    assign w_buf_pop = out_valid && out_ready;
    // The pop with one word remaining carries the last tag
    assign w_buf_din = {(r_remaining == c_LEN_ONE), fifo_dout};

    assign fifo_rd_en = w_rd_en;
    assign out_valid  = (w_count != '0);
    assign out_data   = w_buf_dout[DATA_WIDTH-1:0];
    assign out_last   = w_buf_dout[DATA_WIDTH];
    assign busy       = (r_state != IDLE);
    assign done       = r_done;

    // State register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state, pop strobe and done request; abort overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!abort && start) begin
                    if (burst_len != '0) w_state_nxt = RUN;
                    else                 w_done_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else begin
                    // Independent of out_ready: the buffer absorbs one stall
                    w_rd_en = !fifo_empty && (r_remaining != '0) && (w_count < c_FULL);
                    if (w_rd_en && (r_remaining == c_LEN_ONE)) w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_buf_pop && (w_count == c_CNT_ONE)) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Words still to pop: loaded on start, decremented per pop, cleared on abort
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_remaining <= '0;
        end else if (abort) begin
            r_remaining <= '0;
        end else if ((r_state == IDLE) && start && (burst_len != '0)) begin
            r_remaining <= burst_len;
        end else if (w_rd_en) begin
            r_remaining <= r_remaining - c_LEN_ONE;
        end
    end

    // Registered one-cycle completion pulse
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) r_done <= 1'b0;
        else       r_done <= w_done_nxt;
    end

    fifo_skid_buf #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid_buf (
        .clk   (clk),
        .rst_  (rst_),
        .push  (w_rd_en),
        .din   (w_buf_din),
        .pop   (w_buf_pop),
        .dout  (w_buf_dout),
        .count (w_count),
        .flush (abort)
    );

endmodule : fifo_burst_reader
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_burst_reader
//  Purpose  : Self-checking bench for fifo_burst_reader with a queue-based
//             FIFO model and a burst-level scoreboard.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_;
    logic          start, abort, fifo_empty, fifo_rd_en;
    logic          out_valid, out_ready, out_last, busy, done;
    logic [LW-1:0] burst_len;
    logic [DW-1:0] fifo_dout, out_data;

    int checks = 0;
    int errors = 0;

    // FIFO contents, head at index 0
    logic [DW-1:0] q[$];
    logic          wr_pend = 1'b0;
    logic [DW-1:0] wr_word = '0;
    logic [DW-1:0] last_popped = '0;

    // Values seen just before the upcoming rising edge
    logic          s_rd, s_valid, s_last, s_done, s_busy, s_empty, s_ready, s_acc;
    logic [DW-1:0] s_data;

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .start      (start),
        .burst_len  (burst_len),
        .abort      (abort),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic void drive_fifo();
        fifo_empty = (q.size() == 0);
        fifo_dout  = (q.size() != 0) ? q[0] : '0;
    endfunction

    // Called at a falling edge with inputs set: sample, cross one rising edge,
    // then apply the FIFO pop/write that happened at that edge.
    task automatic tick();
        #1;
        s_rd    = fifo_rd_en;
        s_valid = out_valid;
        s_data  = out_data;
        s_last  = out_last;
        s_done  = done;
        s_busy  = busy;
        s_empty = fifo_empty;
        s_ready = out_ready;
        s_acc   = out_valid && out_ready;
        @(negedge clk);
        if (s_rd && q.size() != 0) last_popped = q.pop_front();
        if (wr_pend) begin q.push_back(wr_word); wr_pend = 1'b0; end
        drive_fifo();
    endtask

    task automatic test_reset();
        rst_ = 1'b1; start = 1'b0; burst_len = '0; abort = 1'b0; out_ready = 1'b0;
        q.delete(); drive_fifo();
        #1 rst_ = 1'b0;
        #2;
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00)  begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
        checks++; if (out_last !== 1'b0)   begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b want 0", done); end
        @(negedge clk); rst_ = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int pops = 0, first_rd = -1, last_rd = -1, first_acc = -1, last_acc = -1, dones = 0, done_c = -1;
        logic [DW-1:0] got[$];
        logic          lasts[$];
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(8'(8'h11 + i));
        drive_fifo();
        out_ready = 1'b1; burst_len = 8'd4; start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick(); start = 1'b0;
            if (s_rd) begin pops++; if (first_rd < 0) first_rd = c; last_rd = c; end
            if (s_acc) begin got.push_back(s_data); lasts.push_back(s_last); if (first_acc < 0) first_acc = c; last_acc = c; end
            if (s_done) begin dones++; done_c = c; end
        end
        checks++; if (pops != 4) begin errors++; $display("FAIL basic_pops got %0d want 4", pops); end
        checks++; if (last_rd - first_rd != 3) begin errors++; $display("FAIL basic_rd_consecutive span %0d want 3", last_rd - first_rd); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== 8'(8'h11 + i)) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, got[i], 8'(8'h11 + i)); end
            checks++; if (lasts[i] !== (i == 3)) begin errors++; $display("FAIL basic_last[%0d] got %b want %b", i, lasts[i], (i == 3)); end
        end
        checks++; if (last_acc - first_acc != 3) begin errors++; $display("FAIL basic_out_consecutive span %0d want 3", last_acc - first_acc); end
        checks++; if (dones != 1 || done_c != last_acc + 1) begin errors++; $display("FAIL basic_done count %0d at %0d want 1 at %0d", dones, done_c, last_acc + 1); end
        checks++; if (q.size() != 2 || q[0] !== 8'h15 || q[1] !== 8'h16) begin errors++; $display("FAIL basic_fifo_left size %0d head %h want 2 head 15", q.size(), q[0]); end
    endtask

    task automatic test_backpressure();
        int pops = 0, dones = 0;
        logic [DW-1:0] got[$];
        logic          lasts[$];
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(8'(8'h11 + i));
        drive_fifo();
        out_ready = 1'b0; burst_len = 8'd4; start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(); start = 1'b0;
            if (s_rd) pops++;
            if (s_valid) begin
                checks++; if (s_data !== 8'h11) begin errors++; $display("FAIL bp_hold_data cycle %0d got %h want 11", c, s_data); end
            end
        end
        checks++; if (pops != 2) begin errors++; $display("FAIL bp_stall_pops got %0d want 2", pops); end
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid got %b want 1", s_valid); end
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (s_rd) pops++;
            if (s_acc) begin got.push_back(s_data); lasts.push_back(s_last); end
            if (s_done) dones++;
        end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (got[i] !== 8'(8'h11 + i) || lasts[i] !== (i == 3)) begin errors++; $display("FAIL bp_word[%0d] got %h/%b want %h/%b", i, got[i], lasts[i], 8'(8'h11 + i), (i == 3)); end
        end
        checks++; if (pops != 4 || dones != 1) begin errors++; $display("FAIL bp_totals pops %0d done %0d want 4 1", pops, dones); end
    endtask

    task automatic test_slow_fifo();
        int nw = 0, dones = 0, busy_drop = 0, busy_after = 0;
        logic [DW-1:0] got[$];
        logic          lasts[$];
        q.delete(); drive_fifo();
        out_ready = 1'b1; burst_len = 8'd3; start = 1'b1;
        tick(); start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c % 3 == 0 && nw < 3) begin wr_pend = 1'b1; wr_word = 8'(8'hA0 + nw); nw++; end
            tick();
            if (s_acc) begin got.push_back(s_data); lasts.push_back(s_last); end
            if (s_done) dones++;
            else if (dones == 0 && !s_busy) busy_drop++;
            else if (dones != 0 && s_busy) busy_after++;
        end
        checks++; if (busy_drop != 0) begin errors++; $display("FAIL slow_busy_drop got %0d cycles want 0", busy_drop); end
        checks++; if (busy_after != 0) begin errors++; $display("FAIL slow_busy_after got %0d cycles want 0", busy_after); end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL slow_count got %0d want 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (got[i] !== 8'(8'hA0 + i) || lasts[i] !== (i == 2)) begin errors++; $display("FAIL slow_word[%0d] got %h/%b want %h/%b", i, got[i], lasts[i], 8'(8'hA0 + i), (i == 2)); end
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL slow_done got %0d want 1", dones); end
    endtask

    task automatic test_zero_len();
        int rds = 0, busys = 0, dones = 0, done_c = -1;
        q.delete(); q.push_back(8'h5A); q.push_back(8'h5B); drive_fifo();
        out_ready = 1'b1; burst_len = 8'd0; start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick(); start = 1'b0;
            if (s_rd) rds++;
            if (s_busy) busys++;
            if (s_done) begin dones++; done_c = c; end
        end
        checks++; if (rds != 0) begin errors++; $display("FAIL zero_rd got %0d want 0", rds); end
        checks++; if (busys != 0) begin errors++; $display("FAIL zero_busy got %0d want 0", busys); end
        checks++; if (dones != 1 || done_c != 1) begin errors++; $display("FAIL zero_done count %0d at %0d want 1 at 1", dones, done_c); end
        checks++; if (q.size() != 2) begin errors++; $display("FAIL zero_fifo got %0d want 2", q.size()); end
    endtask

    task automatic test_abort();
        int nacc = 0, rds = 0, dones = 0, valids = 0;
        logic [DW-1:0] exp[8];
        logic [DW-1:0] got[$];
        logic          lasts[$];
        q.delete();
        for (int i = 0; i < 8; i++) begin exp[i] = 8'($urandom); q.push_back(exp[i]); end
        drive_fifo();
        out_ready = 1'b1; burst_len = 8'd8; start = 1'b1;
        for (int c = 0; c < 20 && nacc < 3; c++) begin
            tick(); start = 1'b0;
            if (s_done) dones++;
            if (s_acc) begin
                checks++; if (s_data !== exp[nacc]) begin errors++; $display("FAIL abort_pre[%0d] got %h want %h", nacc, s_data, exp[nacc]); end
                nacc++;
            end
        end
        abort = 1'b1;
        tick();
        checks++; if (s_rd !== 1'b0) begin errors++; $display("FAIL abort_rd got %b want 0", s_rd); end
        abort = 1'b0;
        tick();
        checks++; if (s_valid !== 1'b0 || s_busy !== 1'b0) begin errors++; $display("FAIL abort_idle valid %b busy %b want 0 0", s_valid, s_busy); end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (s_rd) rds++;
            if (s_done) dones++;
            if (s_valid) valids++;
        end
        checks++; if (rds != 0 || dones != 0 || valids != 0) begin errors++; $display("FAIL abort_quiet rd %0d done %0d valid %0d want 0 0 0", rds, dones, valids); end
        burst_len = 8'd2; start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(); start = 1'b0;
            if (s_acc) begin got.push_back(s_data); lasts.push_back(s_last); end
            if (s_done) dones++;
        end
        for (int i = 0; i < 2; i++) begin
            checks++; if (got[i] !== exp[4 + i] || lasts[i] !== (i == 1)) begin errors++; $display("FAIL abort_restart[%0d] got %h/%b want %h/%b", i, got[i], lasts[i], exp[4 + i], (i == 1)); end
        end
        checks++; if (got.size() != 2 || dones != 1) begin errors++; $display("FAIL abort_restart_totals words %0d done %0d want 2 1", got.size(), dones); end
    endtask

    task automatic test_async_reset();
        int dones = 0;
        logic [DW-1:0] e0;
        logic [DW-1:0] got[$];
        logic          lasts[$];
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(8'(8'hC0 + i));
        drive_fifo();
        out_ready = 1'b1; burst_len = 8'd5; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        #2 rst_ = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin errors++; $display("FAIL arst_stream valid %b data %h last %b want 0 00 0", out_valid, out_data, out_last); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || fifo_rd_en !== 1'b0) begin errors++; $display("FAIL arst_ctrl busy %b done %b rd %b want 0 0 0", busy, done, fifo_rd_en); end
        @(negedge clk); rst_ = 1'b1;
        @(negedge clk);
        e0 = q[0];
        burst_len = 8'd1; start = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick(); start = 1'b0;
            if (s_acc) begin got.push_back(s_data); lasts.push_back(s_last); end
            if (s_done) dones++;
        end
        checks++; if (got.size() != 1 || got[0] !== e0 || lasts[0] !== 1'b1 || dones != 1) begin errors++; $display("FAIL arst_restart words %0d data %h done %0d want 1 %h 1", got.size(), got[0], dones, e0); end
    endtask

    task automatic test_random();
        int len, nacc, nwr, dones, cyc, pops;
        logic          prev_hold;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        logic [DW-1:0] exp[$];
        for (int b = 0; b < 8; b++) begin
            q.delete(); exp.delete();
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) exp.push_back(8'($urandom));
            nwr = $urandom_range(0, len);
            for (int i = 0; i < nwr; i++) q.push_back(exp[i]);
            drive_fifo();
            nacc = 0; dones = 0; cyc = 0; pops = 0; prev_hold = 1'b0; prev_data = '0; prev_last = 1'b0;
            burst_len = 8'(len); start = 1'b1;
            while (dones == 0 && cyc < 300) begin
                if (nwr < len && ($urandom % 2) == 0) begin wr_pend = 1'b1; wr_word = exp[nwr]; nwr++; end
                out_ready = (($urandom % 3) != 0);
                tick(); start = 1'b0; cyc++;
                if (s_rd) begin
                    pops++;
                    checks++; if (s_empty) begin errors++; $display("FAIL rand_pop_empty burst %0d cycle %0d rd 1 want 0", b, cyc); end
                end
                if (prev_hold) begin
                    checks++; if (!s_valid || s_data !== prev_data || s_last !== prev_last) begin errors++; $display("FAIL rand_hold burst %0d got %b/%h/%b want 1/%h/%b", b, s_valid, s_data, s_last, prev_data, prev_last); end
                end
                prev_hold = s_valid && !s_ready; prev_data = s_data; prev_last = s_last;
                if (s_acc) begin
                    checks++; if (s_data !== exp[nacc] || s_last !== (nacc == len - 1)) begin errors++; $display("FAIL rand_word burst %0d idx %0d got %h/%b want %h/%b", b, nacc, s_data, s_last, exp[nacc], (nacc == len - 1)); end
                    nacc++;
                end
                if (s_done) begin
                    dones++;
                    checks++; if (nacc != len) begin errors++; $display("FAIL rand_done_early burst %0d accepted %0d want %0d", b, nacc, len); end
                end
            end
            checks++; if (dones != 1) begin errors++; $display("FAIL rand_timeout burst %0d done %0d want 1", b, dones); end
            checks++; if (pops != len || q.size() != 0) begin errors++; $display("FAIL rand_pops burst %0d got %0d left %0d want %0d 0", b, pops, q.size(), len); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_slow_fifo();
        test_zero_len();
        test_abort();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_burst_reader
`default_nettype wire

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side controller for the team's synchronous FIFO. It pops a programmed number of words (a burst) from the FIFO's show-ahead read port and presents them on a registered valid/ready stream. The last word of each burst is tagged with out_last. It sits between the FIFO and downstream consumers (packetizers, bus masters) so those consumers never drive rd_en directly.

Parameters:
DATA_WIDTH, 8, width of FIFO data and of out_data.
LEN_W, 8, width of burst_len; a burst is at most 2^LEN_W-1 words.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
burst_len  input  LEN_W  number of words to pop; sampled with start.
abort  input  1  terminates the current burst immediately.
fifo_empty  input  1  FIFO empty flag.
fifo_dout  input  DATA_WIDTH  FIFO head word; show-ahead, valid whenever fifo_empty=0.
fifo_rd_en  output  1  FIFO pop strobe; the head word is consumed at the same clock edge.
out_valid  output  1  out_data/out_last are valid.
out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.
out_data  output  DATA_WIDTH  stream data.
out_last  output  1  marks the final word of the burst.
busy  output  1  high in RUN and DRAIN.
done  output  1  one-cycle pulse when the burst completes normally.

Behaviour:
- Reset values (async, rst_=0): state=IDLE, remaining=0, buffer count=0, fifo_rd_en=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
- States: IDLE, RUN, DRAIN.
- IDLE, start=1, burst_len>0: latch remaining=burst_len, go to RUN.
- IDLE, start=1, burst_len=0: stay in IDLE, pulse done the next cycle. No pop occurs.
- start while busy: ignored.
- RUN: fifo_rd_en = !fifo_empty && remaining!=0 && buf_count<2.
  - fifo_rd_en is combinational from registered state and fifo_empty only; it never depends on out_ready.
  - Each pop writes fifo_dout into the buffer tagged last=(remaining==1) and decrements remaining.
  - When the pop with remaining==1 occurs, go to DRAIN.
- DRAIN: no pops. When the buffer becomes empty (the last-tagged word is accepted), pulse done for one cycle and return to IDLE.
- Output buffer: 2 entries, FIFO-ordered.
  - out_valid = (buf_count != 0). out_data/out_last come from the head entry register, so there is no combinational path from fifo_dout to the outputs.
  - Push and pop in the same cycle keep the count unchanged.
  - Steady-state throughput is 1 word/cycle when out_ready stays high and the FIFO is non-empty.
- Latency: a word popped at edge N is visible on out_data after edge N (out_valid high in cycle N+1).
- Stream rules: once out_valid=1, out_data and out_last hold until accepted. The only exceptions are abort and reset.
- fifo_empty during RUN: pops stall and remaining holds. The block stays in RUN indefinitely until data arrives or abort is asserted.
- abort (any state, highest priority): next edge sets state=IDLE, buf_count=0, remaining=0; out_valid drops. fifo_rd_en is forced low in the abort cycle. done is not pulsed. Words already popped are discarded.
- Simultaneous start and abort in IDLE: abort wins; no burst starts.
- Arithmetic: remaining is LEN_W bits and never decrements below 0; buf_count is 2 bits, range 0..2.
- busy = (state != IDLE).

Decomposition:
- Shared package fifo_pkg: rd_state_e enum (IDLE, RUN, DRAIN) and a localparam for buffer depth (2). Keep DATA_WIDTH as a module parameter.
- One natural sub-module, fifo_skid_buf: 2-entry registered buffer carrying {last, data}. Ports: push/din, pop/dout, count, flush. The top-level holds the FSM, the remaining counter and rd_en generation.

Test Plan:
- FIFO preloaded with 0x11..0x16, start with burst_len=4, out_ready=1 → fifo_rd_en high 4 consecutive cycles. out_data 0x11,0x12,0x13,0x14 on consecutive cycles with out_last only on 0x14. done pulses once. FIFO is left holding 0x15,0x16.
- Same preload, burst_len=4, out_ready held low for 5 cycles then high → exactly 2 pops before the stall. out_data stays 0x11 while stalled. Then all 4 words are delivered in order with no loss or duplication.
- Empty FIFO, start with burst_len=3, then write 0xA0,0xA1,0xA2 at 1-word-per-3-cycles → busy stays high. Three words are delivered in order, last on 0xA2, then done.
- start with burst_len=0 → no fifo_rd_en. done pulses one cycle later. busy never asserts.
- burst_len=8 with FIFO holding 8 words; abort asserted after the 3rd accepted word → out_valid low next cycle and no further pops. No done pulse. A new start with burst_len=2 returns the next 2 FIFO words.
- rst_ asserted low mid-burst (asynchronously, between edges) → all outputs go to reset values immediately. After release, start with burst_len=1 behaves normally.
